// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for a single-port synchronous memory
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_cs_n,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  // Extra WAIT cycles beyond the first; counter ends at zero on the last WAIT cycle.
  localparam logic [1:0] CNT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_d;
  logic            r_owner_d;
  logic [1:0]      r_cnt;
  logic            r_mem_cs_n;
  logic            r_mem_we;
  logic [BW-1:0]   r_mem_be;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_i_rdata;
  logic [DW-1:0]   r_d_rdata;
  logic            w_gnt_i;
  logic            w_gnt_d;
  logic            w_pick_d;
  logic            w_resp;
  logic [DW-1:0]   w_d_result;
  logic            w_unused;

  // Fetches are word reads, so the low address bits are dropped.
  assign w_unused = ^i_addr[1:0];

  // Next state and round-robin grant; grants only from IDLE and only out of reset.
  always_comb begin
    w_next   = r_state;
    w_gnt_i  = 1'b0;
    w_gnt_d  = 1'b0;
    w_pick_d = d_req && (!i_req || !r_last_d);
    case (r_state)
      S_IDLE: begin
        if (rst && (i_req || d_req)) begin
          w_gnt_d = w_pick_d;
          w_gnt_i = !w_pick_d;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: w_next = (MEM_LAT > 1) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 2'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_resp     = rst && (r_state == S_RESP);
  assign w_d_result = r_mem_we ? '0 : mem_rdata;

  assign i_gnt     = w_gnt_i;
  assign d_gnt     = w_gnt_d;
  assign i_rvalid  = w_resp && !r_owner_d;
  assign d_rvalid  = w_resp && r_owner_d;
  assign i_rdata   = (w_resp && !r_owner_d) ? mem_rdata : r_i_rdata;
  assign d_rdata   = (w_resp && r_owner_d) ? w_d_result : r_d_rdata;
  assign mem_cs_n  = r_mem_cs_n;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // State, arbitration history, latched memory request and held read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_owner_d   <= 1'b0;
      r_cnt       <= 2'd0;
      r_mem_cs_n  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state    <= w_next;
      r_mem_cs_n <= !(w_gnt_i || w_gnt_d);
      if (w_gnt_i) begin
        r_owner_d  <= 1'b0;
        r_last_d   <= 1'b0;
        r_mem_we   <= 1'b0;
        r_mem_be   <= '1;
        r_mem_addr <= {i_addr[AW-1:2], 2'b00};
      end
      if (w_gnt_d) begin
        r_owner_d   <= 1'b1;
        r_last_d    <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_be    <= d_be;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == S_RESP) begin
        if (r_owner_d) r_d_rdata <= w_d_result;
        else           r_i_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at read latencies 1 and 3
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  int          n_total;
  int          n_pass;

  logic        a_i_req, a_d_req, a_d_we;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
  logic [3:0]  a_d_be;
  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_i_rdata, a_d_rdata;
  logic        a_cs_n, a_we;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic [31:0] mem1 [0:255];

  logic        b_i_req, b_d_req, b_d_we;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
  logic [3:0]  b_d_be;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_i_rdata, b_d_rdata;
  logic        b_cs_n, b_we;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata_unused, b_p0, b_p1, b_p2;
  logic [31:0] mem3 [0:255];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_cs_n(a_cs_n), .mem_we(a_we), .mem_be(a_be), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(a_rd)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_cs_n(b_cs_n), .mem_we(b_we), .mem_be(b_be), .mem_addr(b_addr), .mem_wdata(b_wdata_unused),
    .mem_rdata(b_p2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Latency-1 memory: byte-enabled writes, registered read data.
  always @(posedge clk) begin
    if (!rst) begin
      a_rd     <= '0;
      mem1[0]  <= 32'h00000013;
      mem1[1]  <= 32'h00500093;
      mem1[64] <= 32'h11223344;
    end else if (!a_cs_n) begin
      if (a_we) begin
        for (int k = 0; k < 4; k++)
          if (a_be[k]) mem1[a_addr[9:2]][8*k +: 8] <= a_wdata[8*k +: 8];
      end else begin
        a_rd <= mem1[a_addr[9:2]];
      end
    end
  end

  // Latency-3 read-only memory: read data passes through a three-stage delay line.
  always @(posedge clk) begin
    b_p1 <= b_p0;
    b_p2 <= b_p1;
    if (!rst) begin
      b_p0    <= '0;
      mem3[0] <= 32'h12345678;
      mem3[8] <= 32'hCAFEF00D;
    end else if (!b_cs_n && !b_we) begin
      b_p0 <= mem3[b_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    a_i_req = 1'b1; a_i_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_be = 4'h0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_i_req = 1'b0; b_i_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_be = 4'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0;

    // Reset held with a fetch pending.
    tick;
    tick;
    chk("rst_i_gnt", 32'(a_i_gnt), 32'd0);
    chk("rst_cs_n", 32'(a_cs_n), 32'd1);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_be", 32'(a_be), 32'd0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_wdata", a_wdata, 32'h0);
    chk("rst_i_rdata", a_i_rdata, 32'h0);
    chk("rst_d_rdata", a_d_rdata, 32'h0);
    chk("rst_b_cs_n", 32'(b_cs_n), 32'd1);

    // Release reset: fetch of address 0 is granted in the first IDLE cycle.
    rst = 1'b1;
    #1;
    chk("rel_i_gnt", 32'(a_i_gnt), 32'd1);
    chk("rel_d_gnt", 32'(a_d_gnt), 32'd0);
    tick;
    a_i_req = 1'b0;
    chk("rel_cs_low", 32'(a_cs_n), 32'd0);
    chk("rel_addr", a_addr, 32'h0);
    tick;
    chk("rel_i_rvalid", 32'(a_i_rvalid), 32'd1);
    chk("rel_i_rdata", a_i_rdata, 32'h00000013);
    chk("rel_cs_high", 32'(a_cs_n), 32'd1);
    tick;
    chk("rel_rvalid_off", 32'(a_i_rvalid), 32'd0);

    // Unaligned fetch address is word-aligned on the memory side.
    a_i_req = 1'b1;
    a_i_addr = 32'h00000006;
    #1;
    chk("f6_gnt", 32'(a_i_gnt), 32'd1);
    tick;
    a_i_req = 1'b0;
    chk("f6_cs", 32'(a_cs_n), 32'd0);
    chk("f6_addr", a_addr, 32'h00000004);
    chk("f6_be", 32'(a_be), 32'hF);
    chk("f6_we", 32'(a_we), 32'd0);
    tick;
    chk("f6_rvalid", 32'(a_i_rvalid), 32'd1);
    chk("f6_rdata", a_i_rdata, 32'h00500093);
    tick;

    // Both ports requesting continuously: D, I, D, I, one grant every 3 cycles.
    a_d_we = 1'b0; a_d_be = 4'hF; a_d_addr = 32'h100;
    a_i_req = 1'b1; a_d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_d_gnt", 32'(a_d_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_i_gnt", 32'(a_i_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick;
      chk("rr_issue_nogrant", 32'(a_i_gnt | a_d_gnt), 32'd0);
      tick;
      chk("rr_resp_nogrant", 32'(a_i_gnt | a_d_gnt), 32'd0);
      chk("rr_d_rvalid", 32'(a_d_rvalid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_i_rvalid", 32'(a_i_rvalid), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) chk("rr_d_rdata", a_d_rdata, 32'h11223344);
      else            chk("rr_i_rdata", a_i_rdata, 32'h00500093);
      tick;
    end
    a_i_req = 1'b0; a_d_req = 1'b0;

    // Half-word store, then reload to see merged bytes.
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011; a_d_addr = 32'h100; a_d_wdata = 32'hDEADBEEF;
    #1;
    chk("st_gnt", 32'(a_d_gnt), 32'd1);
    tick;
    a_d_req = 1'b0;
    chk("st_cs", 32'(a_cs_n), 32'd0);
    chk("st_we", 32'(a_we), 32'd1);
    chk("st_be", 32'(a_be), 32'h3);
    chk("st_addr", a_addr, 32'h100);
    chk("st_wdata", a_wdata, 32'hDEADBEEF);
    tick;
    chk("st_cs_once", 32'(a_cs_n), 32'd1);
    chk("st_rvalid", 32'(a_d_rvalid), 32'd1);
    chk("st_rdata", a_d_rdata, 32'h0);
    chk("st_i_hold", a_i_rdata, 32'h00500093);
    tick;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_be = 4'hF;
    #1;
    chk("ld_gnt", 32'(a_d_gnt), 32'd1);
    tick;
    a_d_req = 1'b0;
    tick;
    chk("ld_rvalid", 32'(a_d_rvalid), 32'd1);
    chk("ld_rdata", a_d_rdata, 32'h1122BEEF);
    tick;

    // Latency 3: load completes 4 cycles after grant; fetch raised in WAIT waits for IDLE.
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 32'h20;
    #1;
    chk("l3_d_gnt", 32'(b_d_gnt), 32'd1);
    tick;
    b_d_req = 1'b0;
    chk("l3_cs", 32'(b_cs_n), 32'd0);
    chk("l3_be", 32'(b_be), 32'hF);
    chk("l3_we", 32'(b_we), 32'd0);
    tick;
    b_i_req = 1'b1;
    #1;
    chk("l3_w1_i_gnt", 32'(b_i_gnt), 32'd0);
    chk("l3_w1_cs", 32'(b_cs_n), 32'd1);
    tick;
    chk("l3_w2_i_gnt", 32'(b_i_gnt), 32'd0);
    chk("l3_w2_rvalid", 32'(b_d_rvalid), 32'd0);
    tick;
    chk("l3_rvalid", 32'(b_d_rvalid), 32'd1);
    chk("l3_rdata", b_d_rdata, 32'hCAFEF00D);
    chk("l3_resp_i_gnt", 32'(b_i_gnt), 32'd0);
    tick;
    chk("l3_idle_i_gnt", 32'(b_i_gnt), 32'd1);
    tick;
    b_i_req = 1'b0;
    tick;
    tick;
    chk("l3_i_early", 32'(b_i_rvalid), 32'd0);
    tick;
    chk("l3_i_rvalid", 32'(b_i_rvalid), 32'd1);
    chk("l3_i_rdata", b_i_rdata, 32'h12345678);
    tick;

    // Reset during WAIT aborts the load with no late response.
    b_d_req = 1'b1;
    #1;
    chk("ab_gnt", 32'(b_d_gnt), 32'd1);
    tick;
    b_d_req = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    chk("ab_rst_rvalid", 32'(b_d_rvalid), 32'd0);
    tick;
    chk("ab_cs", 32'(b_cs_n), 32'd1);
    chk("ab_rvalid", 32'(b_d_rvalid), 32'd0);
    chk("ab_rdata", b_d_rdata, 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("ab_post_rvalid", 32'(b_d_rvalid | b_i_rvalid), 32'd0);
      chk("ab_post_cs", 32'(b_cs_n), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, synchronous-read, byte-addressed memory between the instruction-fetch port (I) and the load/store data port (D) of the unpipelined RISC-V core. It sequences every access: it picks a winner, drives the memory's active-low chip select for exactly one cycle, waits out the fixed read latency, and returns data with a one-cycle valid pulse. It sits between the fetch/LSU logic and the memory, and it is the only driver of the memory's control pins.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 bits
- MEM_LAT, 1, memory read latency in cycles from the cs_n-low cycle to the cycle mem_rdata is valid; legal range 1..4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  AW  fetch byte address
- i_gnt  out  1  one-cycle grant pulse to fetch
- i_rvalid  out  1  one-cycle pulse: i_rdata is valid
- i_rdata  out  DW  fetched instruction word
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle grant pulse to data port
- d_rvalid  out  1  one-cycle completion pulse for loads and stores
- d_rdata  out  DW  load data; 0 on store completion
- mem_cs_n  out  1  memory chip select, active-low
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory byte address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction is outstanding.
- IDLE:
  - If any req is high, assert the winner's gnt combinationally in this cycle.
  - Register the winner's request into mem_* and go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE: mem_cs_n = 0 for exactly this cycle. Go to WAIT if MEM_LAT > 1, else go to RESP.
- WAIT: a down-counter runs for MEM_LAT-1 cycles, then the FSM goes to RESP.
- RESP:
  - Pulse the owner's rvalid.
  - rdata = mem_rdata for reads; d_rdata = 0 for stores; the non-owner's rdata holds its last value.
  - Go to IDLE.
- Arbitration is round-robin:
  - A sole requester wins.
  - When both request, the port not granted last wins.
  - last_gnt updates on every grant and resets to I, so D wins the first tie after reset.
- A fetch is always a word read: mem_we = 0, mem_be = all ones, mem_addr = {i_addr[AW-1:2], 2'b00}.
- A data access passes d_we, d_be and d_wdata through; d_addr is forwarded unmodified (alignment is the LSU's responsibility).
- mem_we, mem_be, mem_addr and mem_wdata hold their values from ISSUE through RESP; they are don't-care to the memory outside ISSUE.
- Requests seen in ISSUE, WAIT or RESP are not granted and stay pending. A req dropped before its gnt has no effect.

## Timing
- Grant in cycle T → mem_cs_n low in T+1 → rvalid in T+1+MEM_LAT → next gnt no earlier than T+2+MEM_LAT.
- Throughput is one access per MEM_LAT+2 cycles.
- i_gnt and d_gnt are never high together. i_rvalid and d_rvalid are never high together.
- Reset (rst = 0 sampled at posedge) forces:
  - state = IDLE, last_gnt = I
  - mem_cs_n = 1, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0
  - i_rdata = 0, d_rdata = 0, counter = 0
- While rst = 0, gnt and rvalid are 0 regardless of req.
- Reset in any state aborts the transaction: no rvalid, and no cs_n pulse in the following cycle.

## Test plan
- Reset with i_req = 1 and rst = 0 → no gnt, mem_cs_n = 1. Release reset → i_gnt in the first IDLE cycle, mem_cs_n low in the next cycle, mem_addr = 0x00000000.
- MEM_LAT = 1, fetch at i_addr = 0x00000006 with the memory word at 0x4 = 0x00500093 → mem_addr = 0x00000004, mem_be = 4'hF, i_rvalid 2 cycles after i_gnt, i_rdata = 0x00500093.
- i_req and d_req held high together from reset → grants alternate D, I, D, I; each gnt is MEM_LAT+2 cycles apart.
- Store d_addr = 0x100, d_be = 4'b0011, d_wdata = 0xDEADBEEF → mem_we = 1, mem_be = 4'b0011, mem_cs_n low for one cycle, d_rvalid pulse with d_rdata = 0. A following load of 0x100 returns 0x????BEEF (upper bytes = prior contents).
- MEM_LAT = 3, load d_addr = 0x20 → d_rvalid exactly 4 cycles after d_gnt. An i_req raised during WAIT gets no i_gnt until IDLE.
- rst = 0 asserted in the WAIT state → next cycle IDLE, no rvalid, mem_cs_n = 1, and no stale response after reset is released.
